// File: rtl/approx_mul_ha_pipe.sv
// Pipelined unsigned multiplier built from row-pair half-adder arrays,
// with per-transaction OR-sum approximation in the low columns.
module approx_mul_ha_pipe #(
  parameter int WIDTH       = 8,
  parameter int APPROX_COLS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_x,
  input  logic [WIDTH-1:0]   in_y,
  input  logic               in_approx,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               out_approx,
  output logic               busy
);

  localparam int HALF = WIDTH / 2;
  localparam int PW   = 2 * WIDTH;

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("approx_mul_ha_pipe: WIDTH must be even and >= 4");
  end
  if (APPROX_COLS < 1 || APPROX_COLS > WIDTH) begin : g_bad_cols
    $error("approx_mul_ha_pipe: APPROX_COLS out of range");
  end

  logic v1, v2, v3;
  logic en1, en2, en3;

  logic [WIDTH-1:0] x1, y1;
  logic             ap1, ap2, ap3;

  logic [HALF-1:0][WIDTH:0]   sum_d, sum2;
  logic [HALF-1:0][WIDTH-2:0] cy_d, cy2;
  logic [PW-1:0]              prod_d, p3;

  // A stage loads when its successor is empty or moving on.
  assign en3 = !v3 | out_ready;
  assign en2 = !v2 | en3;
  assign en1 = !v1 | en2;

  assign in_ready   = en1;
  assign out_valid  = v3;
  assign out_p      = p3;
  assign out_approx = ap3;
  assign busy       = v1 | v2 | v3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1  <= 1'b0;
      x1  <= '0;
      y1  <= '0;
      ap1 <= 1'b0;
    end else if (en1) begin
      v1 <= in_valid;
      if (in_valid) begin
        x1  <= in_x;
        y1  <= in_y;
        ap1 <= in_approx;
      end
    end
  end

  // Column c pairs top bit a_c with bottom bit b_(c-1).
  always_comb begin
    sum_d = '0;
    cy_d  = '0;
    for (int k = 0; k < HALF; k++) begin
      sum_d[k][0]     = y1[0] & x1[2*k];
      sum_d[k][WIDTH] = y1[WIDTH-1] & x1[2*k+1];
      for (int c = 1; c < WIDTH; c++) begin
        if (ap1 && c < APPROX_COLS) begin
          sum_d[k][c] = (y1[c] & x1[2*k]) | (y1[c-1] & x1[2*k+1]);
        end else begin
          sum_d[k][c]  = (y1[c] & x1[2*k]) ^ (y1[c-1] & x1[2*k+1]);
          cy_d[k][c-1] = (y1[c] & x1[2*k]) & (y1[c-1] & x1[2*k+1]);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2   <= 1'b0;
      sum2 <= '0;
      cy2  <= '0;
      ap2  <= 1'b0;
    end else if (en2) begin
      v2 <= v1;
      if (v1) begin
        sum2 <= sum_d;
        cy2  <= cy_d;
        ap2  <= ap1;
      end
    end
  end

  // Carry bit for column c carries weight 2^(c+1), stored at index c-1.
  always_comb begin
    prod_d = '0;
    for (int k = 0; k < HALF; k++) begin
      prod_d = prod_d
             + ((PW'(sum2[k]) + (PW'(cy2[k]) << 2)) << (2*k));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3  <= 1'b0;
      p3  <= '0;
      ap3 <= 1'b0;
    end else if (en3) begin
      v3 <= v2;
      if (v2) begin
        p3  <= prod_d;
        ap3 <= ap2;
      end
    end
  end

endmodule

// File: tb/tb_approx_mul_ha_pipe.sv
// Bench for approx_mul_ha_pipe: directed handshake cases plus a
// randomized scoreboard at WIDTH 4, 8 and 16.
module tb_approx_mul_ha_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, in_valid, out_ready, in_approx;
  logic [7:0]  x8, y8;
  logic [3:0]  x4, y4;
  logic [15:0] x16, y16;

  logic rdy8, ov8, oa8, busy8;
  logic [15:0] p8;
  logic rdy4, ov4, oa4, busy4;
  logic [7:0]  p4;
  logic rdy16, ov16, oa16, busy16;
  logic [31:0] p16;

  int n_chk = 0;
  int n_pass = 0;

  longint q8[$], q4[$], q16[$];
  bit     qt8[$];

  approx_mul_ha_pipe #(.WIDTH(8), .APPROX_COLS(4)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(rdy8),
    .in_x(x8), .in_y(y8), .in_approx(in_approx),
    .out_valid(ov8), .out_ready(out_ready),
    .out_p(p8), .out_approx(oa8), .busy(busy8)
  );

  approx_mul_ha_pipe #(.WIDTH(4), .APPROX_COLS(1)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(rdy4),
    .in_x(x4), .in_y(y4), .in_approx(in_approx),
    .out_valid(ov4), .out_ready(out_ready),
    .out_p(p4), .out_approx(oa4), .busy(busy4)
  );

  approx_mul_ha_pipe #(.WIDTH(16), .APPROX_COLS(5)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(rdy16),
    .in_x(x16), .in_y(y16), .in_approx(in_approx),
    .out_valid(ov16), .out_ready(out_ready),
    .out_p(p16), .out_approx(oa16), .busy(busy16)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else
      n_pass++;
  endtask

  // Exact product minus the unit lost wherever an OR column sees a=b=1.
  function automatic longint model(longint x, longint y, bit ap,
                                   int w, int ac);
    longint p;
    p = x * y;
    if (ap)
      for (int k = 0; k < w / 2; k++)
        for (int c = 1; c < ac && c < w; c++)
          if (((x >> (2*k)) & 1) != 0 && ((x >> (2*k+1)) & 1) != 0 &&
              ((y >> c) & 1) != 0 && ((y >> (c-1)) & 1) != 0)
            p -= longint'(1) << (c + 2*k);
    return p;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && rdy8) begin
        q8.push_back(model(longint'(x8), longint'(y8), in_approx, 8, 4));
        qt8.push_back(in_approx);
      end
      if (in_valid && rdy4)
        q4.push_back(longint'(x4) * longint'(y4));
      if (in_valid && rdy16)
        q16.push_back(model(longint'(x16), longint'(y16),
                            in_approx, 16, 5));
      if (ov8 && out_ready) begin
        if (q8.size() == 0) chk("unexp8", 1, 0);
        else begin
          chk("p8", p8, q8.pop_front());
          chk("tag8", oa8, qt8.pop_front());
        end
      end
      if (ov4 && out_ready) begin
        if (q4.size() == 0) chk("unexp4", 1, 0);
        else chk("p4", p4, q4.pop_front());
      end
      if (ov16 && out_ready) begin
        if (q16.size() == 0) chk("unexp16", 1, 0);
        else chk("p16", p16, q16.pop_front());
      end
    end
  end

  task automatic set_ops(input logic [7:0] x, input logic [7:0] y,
                         input logic ap);
    x8 = x;
    y8 = y;
    in_approx = ap;
    x4 = 4'($urandom);
    y4 = 4'($urandom);
    x16 = 16'($urandom);
    y16 = 16'($urandom);
  endtask

  // Leaves in_valid high so callers can stream back-to-back.
  task automatic send(input logic [7:0] x, input logic [7:0] y,
                      input logic ap);
    logic acc;
    set_ops(x, y, ap);
    in_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 100 && !acc; i++) begin
      acc = rdy8;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20 && !ov8; i++) begin
      @(posedge clk);
      #1;
    end
    chk(tag, ov8, 1);
  endtask

  task automatic one(input string tag, input logic [7:0] x,
                     input logic [7:0] y, input logic ap,
                     input logic [15:0] exp);
    send(x, y, ap);
    in_valid = 1'b0;
    wait_valid({tag, "_v"});
    chk(tag, p8, exp);
    chk({tag, "_tag"}, oa8, ap);
    @(posedge clk);
    #1;
  endtask

  logic [15:0] sp[3];
  logic        st[3];
  int          n, nacc;
  logic        acc;

  initial begin
    sp = '{16'd0, 16'd63835, 16'd14450};
    st = '{1'b0, 1'b1, 1'b0};
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    set_ops(8'd0, 8'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ov", ov8, 0);
    chk("rst_p", p8, 0);
    chk("rst_tag", oa8, 0);
    chk("rst_busy", busy8, 0);
    chk("rst_rdy", rdy8, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency counted in edges, the accepting edge being the first.
    send(8'd255, 8'd255, 1'b0);
    in_valid = 1'b0;
    n = 1;
    while (!ov8 && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", n, 3);
    chk("ex255_p", p8, 65025);
    chk("ex255_tag", oa8, 0);
    @(posedge clk);
    #1;

    one("ap255", 8'd255, 8'd255, 1'b1, 16'd63835);
    one("ap3x1", 8'd3, 8'd1, 1'b1, 16'd3);
    one("ap1x1", 8'd1, 8'd1, 1'b1, 16'd1);
    one("ex170", 8'd170, 8'd85, 1'b0, 16'd14450);

    send(8'd0, 8'd0, 1'b0);
    send(8'd255, 8'd255, 1'b1);
    send(8'd170, 8'd85, 1'b0);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("strm_v", ov8, 1);
      chk("strm_p", p8, sp[i]);
      chk("strm_tag", oa8, st[i]);
      @(posedge clk);
      #1;
    end

    out_ready = 1'b0;
    in_valid = 1'b1;
    nacc = 0;
    for (int i = 0; i < 6; i++) begin
      set_ops(8'($urandom), 8'($urandom), 1'($urandom));
      acc = rdy8;
      @(posedge clk);
      #1;
      if (acc) nacc++;
      if (i >= 2) chk("bp_hold", p8, q8[0]);
    end
    chk("bp_acc", nacc, 3);
    chk("bp_rdy", rdy8, 0);
    chk("bp_v", ov8, 1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("bp_drain", q8.size(), 0);
    chk("bp_busy", busy8, 0);

    send(8'd12, 8'd34, 1'b0);
    send(8'd200, 8'd100, 1'b1);
    in_valid = 1'b0;
    chk("mid_busy", busy8, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ov", ov8, 0);
    chk("arst_p", p8, 0);
    chk("arst_tag", oa8, 0);
    chk("arst_busy", busy8, 0);
    q8.delete();
    qt8.delete();
    q4.delete();
    q16.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("post_ov", ov8, 0);
    chk("post_busy", busy8, 0);

    for (int i = 0; i < 400; i++) begin
      set_ops(8'($urandom), 8'($urandom), 1'($urandom));
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (q8.size() == 0 && q4.size() == 0 && q16.size() == 0) break;
      @(posedge clk);
      #1;
    end
    chk("rnd_q8", q8.size(), 0);
    chk("rnd_q4", q4.size(), 0);
    chk("rnd_q16", q16.size(), 0);
    chk("rnd_busy", busy8 | busy4 | busy16, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
